fpu_wb_queue: RTL and testbench

//  Tracks in-flight FP ops issued by the FP instruction decoder to the FPU, tags each returning FPU result

---
 rtl/fpu_wb_queue_if.sv | 42 ++++
 rtl/fpu_wb_queue.sv | 175 +++++++++++++++++
 tb/tb_fpu_wb_queue.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_wb_queue_if.sv
// Regfile package and the FP issue/result/writeback bus used by fpu_wb_queue.
// reg_pkg is kept here so the interface and the queue share one definition.
package reg_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int WORD_SIZE     = 32;
    localparam int TAG_W         = $clog2(NUM_PHYS_REGS);

    typedef struct packed {
        logic [TAG_W-1:0]     index_in;
        logic [WORD_SIZE-1:0] data_in;
        logic                 en;
    } RegFileWritePort;
endpackage

interface fpu_wb_queue_if #(
    parameter int TAG_W = reg_pkg::TAG_W
);
    // Issue side (decoder -> queue)
    logic                          issue_valid_in;
    logic                          issue_is_mul_in;
    logic [TAG_W-1:0]              issue_dest_in;
    logic                          add_ready_out;
    logic                          mul_ready_out;
    // Result side (FPU -> queue)
    logic [reg_pkg::WORD_SIZE-1:0] fpu_result_in;
    logic                          fpu_valid_in;
    // Writeback side (queue <-> regfile arbiter)
    logic                          wb_grant_in;
    reg_pkg::RegFileWritePort      reg_pkt_out;

    modport master (
        output issue_valid_in, issue_is_mul_in, issue_dest_in,
        output fpu_result_in, fpu_valid_in, wb_grant_in,
        input  add_ready_out, mul_ready_out, reg_pkt_out
    );

    modport slave (
        input  issue_valid_in, issue_is_mul_in, issue_dest_in,
        input  fpu_result_in, fpu_valid_in, wb_grant_in,
        output add_ready_out, mul_ready_out, reg_pkt_out
    );
endinterface

// File: rtl/fpu_wb_queue.sv
// Tags returning FPU results with their physical destination, buffers them and drains them to the regfile.
// Optional feature macro: FPWB_BYPASS_EN (empty-FIFO capture is written through in the same cycle).
module fpu_wb_queue
    import reg_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int FP_MULT_LATENCY = 13,
    parameter int FP_ADD_LATENCY  = 1,
    parameter int TAG_W           = $clog2(NUM_PHYS_REGS)
) (
    input  logic                       clk_in,
    input  logic                       rst_N_in,
    input  logic                       flush_in,
    fpu_wb_queue_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_out,
    output logic                       err_out
);

    localparam int SLOTS = FP_MULT_LATENCY;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TOT_W = $clog2(FP_MULT_LATENCY + DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]     dest;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

    // Slot tracker: slot 0 holds the op whose result is due this cycle.
    logic [SLOTS-1:0] slot_v;
    logic [TAG_W-1:0] slot_dest [SLOTS];

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [TOT_W-1:0] inflight;
    logic [TOT_W-1:0] total_after_pop;
    logic             fifo_nonempty;
    logic             pop;
    logic             credit_ok;
    logic             add_ready;
    logic             mul_ready;
    logic             issue_ok;
    logic             capture;
    logic             miss;
    logic             push;
    logic             bypass;

    // NOTE: every variable assigned in an always_comb block gets a default
    // first, so no path leaves it holding its old value (no inferred latch).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < SLOTS; i++) begin
            inflight = inflight + TOT_W'(slot_v[i]);
        end
    end

    // Credit covers both in-flight ops and buffered entries, so a capture
    // can never find the FIFO full.
    always_comb begin
        fifo_nonempty   = (occupancy_out != '0);
        pop             = fifo_nonempty && bus.wb_grant_in;
        total_after_pop = inflight + TOT_W'(occupancy_out) - TOT_W'(pop);
        credit_ok       = (total_after_pop < TOT_W'(DEPTH));
        mul_ready       = credit_ok;
        add_ready       = credit_ok && !slot_v[FP_ADD_LATENCY];
        issue_ok        = bus.issue_valid_in && !flush_in &&
                          (bus.issue_is_mul_in ? mul_ready : add_ready);
        capture         = slot_v[0] && bus.fpu_valid_in && !flush_in;
        miss            = slot_v[0] && !bus.fpu_valid_in;
    end

    assign bus.add_ready_out = add_ready;
    assign bus.mul_ready_out = mul_ready;

`ifdef FPWB_BYPASS_EN
    assign bypass = capture && !fifo_nonempty;
    assign push   = capture && !(bypass && bus.wb_grant_in);
`else
    assign bypass = 1'b0;
    assign push   = capture;
`endif

    // Head is masked while empty so the port reads all-zero after reset.
    always_comb begin
        bus.reg_pkt_out = '0;
        if (fifo_nonempty) begin
            bus.reg_pkt_out.index_in = mem[rd_ptr].dest;
            bus.reg_pkt_out.data_in  = mem[rd_ptr].data;
            bus.reg_pkt_out.en       = 1'b1;
        end else if (bypass) begin
            bus.reg_pkt_out.index_in = slot_dest[0];
            bus.reg_pkt_out.data_in  = bus.fpu_result_in;
            bus.reg_pkt_out.en       = 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so the shift reads every slot's pre-edge value regardless of loop order.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            slot_v <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_dest[i] <= '0;
            end
        end else if (flush_in) begin
            slot_v <= '0;
        end else begin
            slot_v <= {1'b0, slot_v[SLOTS-1:1]};
            for (int i = 0; i < SLOTS - 1; i++) begin
                slot_dest[i] <= slot_dest[i+1];
            end
            // A new issue lands after the shift, so it wins its slot.
            if (issue_ok) begin
                if (bus.issue_is_mul_in) begin
                    slot_v[FP_MULT_LATENCY-1]    <= 1'b1;
                    slot_dest[FP_MULT_LATENCY-1] <= bus.issue_dest_in;
                end else begin
                    slot_v[FP_ADD_LATENCY-1]    <= 1'b1;
                    slot_dest[FP_ADD_LATENCY-1] <= bus.issue_dest_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            err_out <= 1'b0;
        end else if (flush_in) begin
            err_out <= 1'b0;
        end else if (miss) begin
            err_out <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy_out <= '0;
        end else if (flush_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy_out <= occupancy_out + OCC_W'(1);
                2'b01:   occupancy_out <= occupancy_out - OCC_W'(1);
                default: occupancy_out <= occupancy_out;
            endcase
        end
    end

    // NOTE: the result storage has no reset; stale entries are never visible
    // because the read side is gated by occupancy_out.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= '{dest: slot_dest[0], data: bus.fpu_result_in};
        end
    end

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        !(push && !pop && occupancy_out == OCC_W'(DEPTH)));

    a_no_underflow: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        !(pop && occupancy_out == '0));

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Self-checking bench for fpu_wb_queue: a small FPU model feeds a scoreboard checked at the writeback port.
module tb_fpu_wb_queue;
    import reg_pkg::*;

    localparam int DEPTH = 4;
    localparam int ML    = 13;
    localparam int AL    = 1;
    localparam int NCYC  = 1024;

    typedef struct packed {
        logic [TAG_W-1:0]     dest;
        logic [WORD_SIZE-1:0] data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] occ;
    logic       err;

    fpu_wb_queue_if bus ();

    fpu_wb_queue #(
        .DEPTH          (DEPTH),
        .FP_MULT_LATENCY(ML),
        .FP_ADD_LATENCY (AL)
    ) dut (
        .clk_in       (clk),
        .rst_N_in     (rst_n),
        .flush_in     (flush),
        .bus          (bus),
        .occupancy_out(occ),
        .err_out      (err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t mon_e;

    // FPU model: what the FPU returns in each cycle.
    bit                   due_v    [NCYC];
    bit                   due_live [NCYC];
    bit                   due_drop [NCYC];
    logic [TAG_W-1:0]     due_dest [NCYC];
    logic [WORD_SIZE-1:0] due_data [NCYC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        bus.issue_valid_in = 1'b0;
        bus.fpu_valid_in   = 1'b0;
        bus.fpu_result_in  = $urandom;
        if (cyc < NCYC && due_v[cyc]) begin
            if (!due_drop[cyc]) begin
                bus.fpu_valid_in  = 1'b1;
                bus.fpu_result_in = due_data[cyc];
                if (due_live[cyc]) sb.push_back('{dest: due_dest[cyc], data: due_data[cyc]});
            end
            due_v[cyc] = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input bit is_mul, input int dest, input logic [31:0] data,
                         input bit accept, input bit drop);
        int idx;
        bus.issue_valid_in  = 1'b1;
        bus.issue_is_mul_in = is_mul;
        bus.issue_dest_in   = TAG_W'(dest);
        if (accept) begin
            idx           = cyc + (is_mul ? ML : AL);
            due_v[idx]    = 1'b1;
            due_live[idx] = 1'b1;
            due_drop[idx] = drop;
            due_dest[idx] = TAG_W'(dest);
            due_data[idx] = data;
        end
    endtask

    // Results still owed by the FPU after a flush/reset become stragglers.
    task automatic kill_inflight();
        for (int i = cyc + 1; i < NCYC; i++) due_live[i] = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_occ"}, 64'(occ), 64'(0));
        check({tag, "_en"}, 64'(bus.reg_pkt_out.en), 64'(0));
        check({tag, "_add_rdy"}, 64'(bus.add_ready_out), 64'(1));
        check({tag, "_mul_rdy"}, 64'(bus.mul_ready_out), 64'(1));
    endtask

    // Scoreboard compare on every granted write.
    always @(negedge clk) begin
        if (rst_n && !flush && bus.reg_pkt_out.en && bus.wb_grant_in) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 64'(1), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("wb_index", 64'(bus.reg_pkt_out.index_in), 64'(mon_e.dest));
                check("wb_data", 64'(bus.reg_pkt_out.data_in), 64'(mon_e.data));
            end
        end
    end

    initial begin
        bus.issue_valid_in  = 1'b0;
        bus.issue_is_mul_in = 1'b0;
        bus.issue_dest_in   = '0;
        bus.fpu_result_in   = '0;
        bus.fpu_valid_in    = 1'b0;
        bus.wb_grant_in     = 1'b0;

        // Reset state
        #12;
        check_idle("reset");
        check("reset_err", 64'(err), 64'(0));
        check("reset_pkt", 64'(bus.reg_pkt_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single FADD dest 5, granted
        tick();
        bus.wb_grant_in = 1'b1;
        issue(1'b0, 5, 32'h3F80_0000, 1'b1, 1'b0);
        tick();
        sample();
`ifdef FPWB_BYPASS_EN
        check("fadd_t1_en", 64'(bus.reg_pkt_out.en), 64'(1));
        check("fadd_t1_idx", 64'(bus.reg_pkt_out.index_in), 64'(5));
`else
        check("fadd_t1_en", 64'(bus.reg_pkt_out.en), 64'(0));
`endif
        tick();
        sample();
`ifdef FPWB_BYPASS_EN
        check("fadd_t2_en", 64'(bus.reg_pkt_out.en), 64'(0));
`else
        check("fadd_t2_en", 64'(bus.reg_pkt_out.en), 64'(1));
        check("fadd_t2_idx", 64'(bus.reg_pkt_out.index_in), 64'(5));
        check("fadd_t2_data", 64'(bus.reg_pkt_out.data_in), 64'(32'h3F80_0000));
        check("fadd_t2_occ", 64'(occ), 64'(1));
`endif
        tick();
        sample();
        check_idle("fadd_done");

        // FMUL dest 7: an FADD issued one cycle before the FMUL returns would collide
        tick();
        issue(1'b1, 7, $urandom, 1'b1, 1'b0);
        ticks(ML - AL);
        sample();
        check("mul_coll_add_rdy", 64'(bus.add_ready_out), 64'(0));
        check("mul_coll_mul_rdy", 64'(bus.mul_ready_out), 64'(1));
        issue(1'b0, 8, $urandom, 1'b0, 1'b0);
        tick();
        sample();
        check("mul_due_add_rdy", 64'(bus.add_ready_out), 64'(1));
        ticks(2);
        sample();
        check_idle("mul_done");

        // Credit exhaustion with the port withheld
        bus.wb_grant_in = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            sample();
            check("credit_pre_add_rdy", 64'(bus.add_ready_out), 64'(1));
            issue(1'b0, 16 + k, $urandom, 1'b1, 1'b0);
        end
        tick();
        sample();
        check("credit_full_add_rdy", 64'(bus.add_ready_out), 64'(0));
        check("credit_full_mul_rdy", 64'(bus.mul_ready_out), 64'(0));
        tick();
        sample();
        check("credit_full_occ", 64'(occ), 64'(DEPTH));
        check("credit_full_en", 64'(bus.reg_pkt_out.en), 64'(1));
        tick();
        bus.wb_grant_in = 1'b1;
        sample();
        check("credit_pop_mul_rdy", 64'(bus.mul_ready_out), 64'(1));
        check("credit_pop_add_rdy", 64'(bus.add_ready_out), 64'(1));
        tick();
        bus.wb_grant_in = 1'b0;
        sample();
        check("credit_after_pop_occ", 64'(occ), 64'(DEPTH - 1));
        check("credit_after_pop_rdy", 64'(bus.mul_ready_out), 64'(1));

        // Sustained push+pop at the highest reachable occupancy, across pointer wrap
        issue(1'b0, 32, $urandom, 1'b1, 1'b0);
        tick();
        bus.wb_grant_in = 1'b1;
        issue(1'b0, 33, $urandom, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            sample();
            check("pushpop_occ", 64'(occ), 64'(DEPTH - 1));
            check("pushpop_add_rdy", 64'(bus.add_ready_out), 64'(1));
            issue(1'b0, 40 + k, $urandom, 1'b1, 1'b0);
        end
        ticks(DEPTH + 3);
        sample();
        check_idle("drain");
        check("drain_sb", 64'(sb.size()), 64'(0));

        // Missing FMUL result: sticky error, cleared by flush
        tick();
        issue(1'b1, 9, $urandom, 1'b1, 1'b1);
        ticks(ML);
        sample();
        check("miss_due_err", 64'(err), 64'(0));
        tick();
        sample();
        check("miss_err", 64'(err), 64'(1));
        check("miss_occ", 64'(occ), 64'(0));
        check("miss_en", 64'(bus.reg_pkt_out.en), 64'(0));
        tick();
        issue(1'b1, 11, $urandom, 1'b1, 1'b0);
        ticks(3);
        sample();
        check("miss_sticky_err", 64'(err), 64'(1));
        tick();
        flush = 1'b1;
        kill_inflight();
        tick();
        flush = 1'b0;
        sample();
        check("flush_err", 64'(err), 64'(0));
        check_idle("flush");
        ticks(ML);
        sample();
        check("straggler_err", 64'(err), 64'(0));
        check_idle("straggler");

        // Asynchronous reset in the middle of traffic
        bus.wb_grant_in = 1'b0;
        tick();
        issue(1'b0, 20, $urandom, 1'b1, 1'b0);
        tick();
        issue(1'b1, 21, $urandom, 1'b1, 1'b0);
        tick();
        issue(1'b0, 22, $urandom, 1'b1, 1'b0);
        ticks(2);
        sample();
        check("pre_rst_occ", 64'(occ), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        check("mid_rst_err", 64'(err), 64'(0));
        kill_inflight();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.wb_grant_in = 1'b1;
        ticks(ML + 2);
        sample();
        check_idle("post_rst");
        check("final_sb", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
